// File: rtl/cmd_frame_rx.sv
// K-character framed command receiver: buffers opcode + payload, verifies an additive checksum, commits atomically.
// Optional statistics counters are built when CMD_FRAME_RX_STAT_EN is defined.
module cmd_frame_rx #(
  parameter int                 DATA_W    = 16,
  parameter int                 CTRL_W    = DATA_W / 8,
  parameter int                 MAX_WORDS = 32,
  parameter logic [DATA_W-1:0]  SOF_CODE  = 16'h02BC,
  parameter logic [DATA_W-1:0]  EOF_CODE  = 16'h03BC,
  parameter logic [CTRL_W-1:0]  SOF_CTRL  = 2'b01,
  localparam int                LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                          GT_USRCLK,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             RX_DATA,
  input  logic [CTRL_W-1:0]             RXCTRL,
  output logic [DATA_W-1:0]             CMD_OPCODE,
  output logic [MAX_WORDS*DATA_W-1:0]   CMD_PAYLOAD,
  output logic [LEN_W-1:0]              CMD_LEN,
  output logic                          CMD_VALID,
  output logic                          CMD_ERR_CKSUM,
  output logic                          CMD_ERR_LEN,
  output logic                          CMD_BUSY
`ifdef CMD_FRAME_RX_STAT_EN
  ,
  input  logic                          STAT_CLR,
  output logic [15:0]                   STAT_GOOD,
  output logic [15:0]                   STAT_CKSUM,
  output logic [15:0]                   STAT_LEN
`endif
);

  localparam int FRM_W = MAX_WORDS + 2;
  localparam int CNT_W = $clog2(FRM_W + 1);

  typedef enum logic [1:0] {IDLE, RECV, DROP, CHECK} state_t;

  state_t             state;
  logic [DATA_W-1:0]  rx_data_d1;
  logic [CTRL_W-1:0]  rxctrl_d1;
  logic [DATA_W-1:0]  frame_buf [FRM_W];
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  last;
  logic               sof;
  logic               eof;
  logic               is_data;

  assign sof      = (rxctrl_d1 == SOF_CTRL) && (rx_data_d1 == SOF_CODE);
  assign eof      = (rxctrl_d1 == SOF_CTRL) && (rx_data_d1 == EOF_CODE);
  assign is_data  = (rxctrl_d1 == '0);
  assign CMD_BUSY = (state != IDLE);

  // Stage d1 (input register) -> frame FSM / commit registers
  always_ff @(posedge GT_USRCLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rx_data_d1    <= '0;
      rxctrl_d1     <= '0;
      cnt           <= '0;
      sum           <= '0;
      last          <= '0;
      CMD_OPCODE    <= '0;
      CMD_PAYLOAD   <= '0;
      CMD_LEN       <= '0;
      CMD_VALID     <= 1'b0;
      CMD_ERR_CKSUM <= 1'b0;
      CMD_ERR_LEN   <= 1'b0;
      for (int i = 0; i < FRM_W; i++) frame_buf[i] <= '0;
    end else begin
      rx_data_d1    <= RX_DATA;
      rxctrl_d1     <= RXCTRL;
      CMD_VALID     <= 1'b0;
      CMD_ERR_CKSUM <= 1'b0;
      CMD_ERR_LEN   <= 1'b0;
      unique case (state)
        RECV: begin
          if (!sof && eof) begin
            state <= CHECK;
          end else if (!sof && is_data) begin
            if (cnt == CNT_W'(FRM_W)) begin
              state <= DROP;
            end else begin
              // sum trails by one word so the checksum word never enters it
              frame_buf[cnt] <= rx_data_d1;
              cnt            <= cnt + CNT_W'(1);
              sum            <= sum + last;
              last           <= rx_data_d1;
            end
          end
        end
        DROP: begin
          if (!sof && eof) begin
            CMD_ERR_LEN <= 1'b1;
            state       <= IDLE;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (cnt < CNT_W'(2)) begin
            CMD_ERR_LEN <= 1'b1;
          end else if (sum != last) begin
            CMD_ERR_CKSUM <= 1'b1;
          end else begin
            CMD_VALID  <= 1'b1;
            CMD_OPCODE <= frame_buf[0];
            CMD_LEN    <= LEN_W'(cnt - CNT_W'(2));
            for (int i = 0; i < MAX_WORDS; i++)
              CMD_PAYLOAD[i*DATA_W +: DATA_W] <= (i + 2 < int'(cnt)) ? frame_buf[i+1] : '0;
          end
        end
        default: ;
      endcase
      // SOF restarts reception from any state, including the CHECK cycle
      if (sof) begin
        state <= RECV;
        cnt   <= '0;
        sum   <= '0;
        last  <= '0;
      end
    end
  end

`ifdef CMD_FRAME_RX_STAT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage commit pulses -> statistics counters
  always_ff @(posedge GT_USRCLK or negedge rst_n) begin
    if (!rst_n) begin
      STAT_GOOD  <= '0;
      STAT_CKSUM <= '0;
      STAT_LEN   <= '0;
    end else if (STAT_CLR) begin
      STAT_GOOD  <= '0;
      STAT_CKSUM <= '0;
      STAT_LEN   <= '0;
    end else begin
      if (CMD_VALID)     STAT_GOOD  <= sat_inc(STAT_GOOD);
      if (CMD_ERR_CKSUM) STAT_CKSUM <= sat_inc(STAT_CKSUM);
      if (CMD_ERR_LEN)   STAT_LEN   <= sat_inc(STAT_LEN);
    end
  end
`endif

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Scoreboard bench for cmd_frame_rx: directed frames push expected events, a monitor checks each output pulse.
module tb_cmd_frame_rx;

  localparam int DW  = 16;
  localparam int MW  = 32;
  localparam int PW  = MW * DW;
  localparam int LW  = $clog2(MW + 1);
  localparam logic [15:0] SOF  = 16'h02BC;
  localparam logic [15:0] EOF  = 16'h03BC;
  localparam logic [15:0] IDLK = 16'h00BC;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  RX_DATA = '0;
  logic [1:0]     RXCTRL = '0;
  logic [DW-1:0]  CMD_OPCODE;
  logic [PW-1:0]  CMD_PAYLOAD;
  logic [LW-1:0]  CMD_LEN;
  logic           CMD_VALID, CMD_ERR_CKSUM, CMD_ERR_LEN, CMD_BUSY;
`ifdef CMD_FRAME_RX_STAT_EN
  logic           STAT_CLR = 1'b0;
  logic [15:0]    STAT_GOOD, STAT_CKSUM, STAT_LEN;
`endif

  cmd_frame_rx dut (
    .GT_USRCLK(clk), .rst_n(rst_n), .RX_DATA(RX_DATA), .RXCTRL(RXCTRL),
    .CMD_OPCODE(CMD_OPCODE), .CMD_PAYLOAD(CMD_PAYLOAD), .CMD_LEN(CMD_LEN),
    .CMD_VALID(CMD_VALID), .CMD_ERR_CKSUM(CMD_ERR_CKSUM), .CMD_ERR_LEN(CMD_ERR_LEN),
    .CMD_BUSY(CMD_BUSY)
`ifdef CMD_FRAME_RX_STAT_EN
    , .STAT_CLR(STAT_CLR), .STAT_GOOD(STAT_GOOD), .STAT_CKSUM(STAT_CKSUM), .STAT_LEN(STAT_LEN)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 = CMD_VALID, 1 = CMD_ERR_CKSUM, 2 = CMD_ERR_LEN
  typedef struct {
    int             kind;
    int             cyc;
    logic [DW-1:0]  op;
    logic [LW-1:0]  len;
    logic [PW-1:0]  pl;
  } ev_t;

  ev_t            ev_q[$];
  logic [DW-1:0]  m_op = '0;
  logic [LW-1:0]  m_len = '0;
  logic [PW-1:0]  m_pl = '0;

  task automatic exp_valid(input int c, input logic [DW-1:0] op, input int len, input logic [PW-1:0] pl);
    ev_t e;
    m_op = op; m_len = LW'(len); m_pl = pl;
    e.kind = 0; e.cyc = c; e.op = op; e.len = LW'(len); e.pl = pl;
    ev_q.push_back(e);
  endtask

  task automatic exp_err(input int kind, input int c);
    ev_t e;
    e.kind = kind; e.cyc = c; e.op = m_op; e.len = m_len; e.pl = m_pl;
    ev_q.push_back(e);
  endtask

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge clk) begin
    if (CMD_VALID || CMD_ERR_CKSUM || CMD_ERR_LEN) begin
      int k;
      ev_t e;
      k = (CMD_VALID + CMD_ERR_CKSUM + CMD_ERR_LEN > 1) ? 3 :
          CMD_VALID ? 0 : CMD_ERR_CKSUM ? 1 : 2;
      if (ev_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected no pulse", k, cyc);
      end else begin
        e = ev_q.pop_front();
        chk("pulse_kind", PW'(k), PW'(e.kind));
        chk("pulse_cycle", PW'(cyc), PW'(e.cyc));
        chk("opcode", PW'(CMD_OPCODE), PW'(e.op));
        chk("len", PW'(CMD_LEN), PW'(e.len));
        chk("payload", CMD_PAYLOAD, e.pl);
      end
    end
  end

  logic [DW-1:0] wq[$];

  task automatic put(input logic [DW-1:0] d, input logic [1:0] c);
    @(posedge clk); #1;
    RX_DATA = d; RXCTRL = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(IDLK, 2'b01);
  endtask

  task automatic send_frame(output int eof_cyc);
    put(SOF, 2'b01);
    foreach (wq[i]) put(wq[i], 2'b00);
    put(EOF, 2'b01);
    eof_cyc = cyc;
  endtask

  logic [PW-1:0] pl;
  int ec;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_opcode", PW'(CMD_OPCODE), '0);
    chk("rst_len", PW'(CMD_LEN), '0);
    chk("rst_payload", CMD_PAYLOAD, '0);
    chk("rst_pulses", PW'({CMD_VALID, CMD_ERR_CKSUM, CMD_ERR_LEN}), '0);
    chk("rst_busy", PW'(CMD_BUSY), '0);
    rst_n = 1'b1;
    idle(3);

    // good frame, 2-word payload; busy through CHECK, clear once committed
    wq = '{16'h0001, 16'h1234, 16'h5678, 16'h68AD};
    send_frame(ec);
    pl = '0; pl[0 +: 16] = 16'h1234; pl[16 +: 16] = 16'h5678;
    exp_valid(ec + 3, 16'h0001, 2, pl);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("busy_in_check", PW'(CMD_BUSY), 1);
    @(negedge clk);
    chk("busy_after_commit", PW'(CMD_BUSY), 0);
    idle(4);

    // bad checksum leaves committed outputs alone
    wq = '{16'h0001, 16'h1234, 16'h5678, 16'h68AE};
    send_frame(ec);
    exp_err(1, ec + 3);
    idle(6);

    // single-word frame is too short
    wq = '{16'h00A5};
    send_frame(ec);
    exp_err(2, ec + 3);
    idle(6);

    // zero-length payload
    wq = '{16'hA5A5, 16'hA5A5};
    send_frame(ec);
    exp_valid(ec + 3, 16'hA5A5, 0, '0);
    idle(6);

    // full-size payload of exactly MAX_WORDS words
    wq = {};
    wq.push_back(16'h0100);
    pl = '0;
    for (int i = 0; i < MW; i++) begin
      wq.push_back(16'(i + 1));
      pl[i*16 +: 16] = 16'(i + 1);
    end
    wq.push_back(16'h0310);
    send_frame(ec);
    exp_valid(ec + 3, 16'h0100, MW, pl);
    idle(6);

    // overflow: MAX_WORDS+3 data words, then EOF
    put(SOF, 2'b01);
    for (int i = 0; i < MW + 3; i++) put(16'(i + 16'h40), 2'b00);
    put(EOF, 2'b01);
    ec = cyc;
    exp_err(2, ec + 2);
    @(negedge clk);
    chk("busy_drop_eof", PW'(CMD_BUSY), 1);
    @(negedge clk);
    chk("busy_drop_eof1", PW'(CMD_BUSY), 1);
    @(negedge clk);
    chk("busy_drop_done", PW'(CMD_BUSY), 0);
    idle(4);

    wq = '{16'h0007, 16'h1111, 16'h2222, 16'h3333, 16'h666D};
    send_frame(ec);
    pl = '0; pl[0 +: 16] = 16'h1111; pl[16 +: 16] = 16'h2222; pl[32 +: 16] = 16'h3333;
    exp_valid(ec + 3, 16'h0007, 3, pl);
    idle(6);

    // SOF mid-frame restarts; idle K words inside the frame are skipped
    put(SOF, 2'b01);
    put(16'hDEAD, 2'b00); put(16'hBEEF, 2'b00); put(16'h0001, 2'b00);
    put(SOF, 2'b01);
    put(16'h0010, 2'b00); put(IDLK, 2'b01); put(16'h0001, 2'b00);
    put(16'h0002, 2'b00); put(IDLK, 2'b01); put(16'h0013, 2'b00);
    put(EOF, 2'b01);
    ec = cyc;
    pl = '0; pl[0 +: 16] = 16'h0001; pl[16 +: 16] = 16'h0002;
    exp_valid(ec + 3, 16'h0010, 2, pl);
    idle(6);

    // reset in mid-frame: frame lost, outputs cleared, no pulses
    put(SOF, 2'b01);
    put(16'h0001, 2'b00); put(16'h2222, 2'b00);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    m_op = '0; m_len = '0; m_pl = '0;
    put(EOF, 2'b01);
    idle(6);
    chk("rstmid_opcode", PW'(CMD_OPCODE), '0);
    chk("rstmid_len", PW'(CMD_LEN), '0);
    chk("rstmid_payload", CMD_PAYLOAD, '0);
    chk("rstmid_busy", PW'(CMD_BUSY), '0);

`ifdef CMD_FRAME_RX_STAT_EN
    for (int f = 0; f < 4; f++) begin
      wq = '{16'h0001, 16'h1234, 16'h5678, (f == 3) ? 16'h68AE : 16'h68AD};
      send_frame(ec);
      if (f == 3) exp_err(1, ec + 3);
      else begin
        pl = '0; pl[0 +: 16] = 16'h1234; pl[16 +: 16] = 16'h5678;
        exp_valid(ec + 3, 16'h0001, 2, pl);
      end
      idle(5);
    end
    chk("stat_good", PW'(STAT_GOOD), 3);
    chk("stat_cksum", PW'(STAT_CKSUM), 1);
    chk("stat_len", PW'(STAT_LEN), 0);
    @(posedge clk); #1; STAT_CLR = 1'b1;
    @(posedge clk); #1; STAT_CLR = 1'b0;
    chk("stat_clr_good", PW'(STAT_GOOD), 0);
    chk("stat_clr_cksum", PW'(STAT_CKSUM), 0);
`endif

    idle(4);
    chk("events_drained", PW'(ev_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
